// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - parametrised 4x oversampling UART receiver with status FIFO
module uart_rx_cfg #(
  parameter int CLK_DIV    = 108,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx,
  input  logic                        rready,
  output logic                        rvalid,
  output logic [DATA_BITS-1:0]        rdata,
  output logic                        rperr,
  output logic                        rferr,
  output logic                        rbreak,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_BITS + 3;
  localparam int BW = 4;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  state_t state, state_nx;

  logic [1:0]           sync;
  logic                 s;
  logic [CW-1:0]        tcnt;
  logic                 tick;
  logic                 prev_s;
  logic [1:0]           phase;
  logic [1:0]           ph_now;
  logic                 smp1, smp2;
  logic                 vote;
  logic                 bit_done;
  logic [BW-1:0]        bidx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_acc, zero_acc, perr_r, ferr_r, brk_r;
  logic                 ferr_now, brk_now;
  logic                 push;
  logic [EW-1:0]        entry;

  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]        wptr, rptr;
  logic [AW:0]          count;
  logic                 full, do_pop, do_push;

  assign s        = sync[1];
  assign tick     = (tcnt == CW'(CLK_DIV - 1));
  assign ph_now   = phase + 2'd1;
  assign vote     = (smp1 & smp2) | (smp1 & s) | (smp2 & s);
  assign bit_done = tick && (ph_now == 2'd3);

  // Two-flop synchroniser on the asynchronous rx pin, idles high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], rx};
  end

  // Free-running oversample tick divider
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       tcnt <= '0;
    else if (tick) tcnt <= '0;
    else           tcnt <= tcnt + 1'b1;
  end

  // Frame FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; push fires on the phase-3 tick of the last stop bit
  always_comb begin
    state_nx = state;
    push     = 1'b0;
    case (state)
      S_IDLE:   if (tick && !s && prev_s) state_nx = S_START;
      S_START:  if (bit_done) state_nx = vote ? S_IDLE : S_DATA;
      S_DATA:   if (bit_done && bidx == BW'(DATA_BITS - 1))
                  state_nx = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_done) state_nx = S_STOP;
      S_STOP:   if (bit_done && bidx == BW'(STOP_BITS - 1)) begin
                  state_nx = S_IDLE;
                  push     = 1'b1;
                end
      default:  state_nx = S_IDLE;
    endcase
  end

  // Bit sampling, data shift and per-frame status accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_s   <= 1'b0;
      phase    <= '0;
      smp1     <= 1'b1;
      smp2     <= 1'b1;
      bidx     <= '0;
      shreg    <= '0;
      par_acc  <= 1'b0;
      zero_acc <= 1'b1;
      perr_r   <= 1'b0;
      ferr_r   <= 1'b0;
      brk_r    <= 1'b0;
    end else if (tick) begin
      prev_s <= s;
      if (state == S_IDLE) begin
        phase    <= '0;
        bidx     <= '0;
        par_acc  <= 1'b0;
        zero_acc <= 1'b1;
        perr_r   <= 1'b0;
        ferr_r   <= 1'b0;
        brk_r    <= 1'b0;
      end else begin
        phase <= ph_now;
        if (ph_now == 2'd1) smp1 <= s;
        if (ph_now == 2'd2) smp2 <= s;
        if (ph_now == 2'd3) begin
          case (state)
            S_DATA: begin
              shreg    <= {vote, shreg[DATA_BITS-1:1]};
              par_acc  <= par_acc ^ vote;
              zero_acc <= zero_acc & ~vote;
              bidx     <= (bidx == BW'(DATA_BITS - 1)) ? '0 : bidx + 1'b1;
            end
            S_PARITY: begin
              perr_r   <= (PARITY == 1) ? ~(par_acc ^ vote) : (par_acc ^ vote);
              zero_acc <= zero_acc & ~vote;
            end
            S_STOP: begin
              if (!vote) ferr_r <= 1'b1;
              if (bidx == '0) brk_r <= zero_acc & ~vote;
              bidx <= bidx + 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // The final stop vote is folded in combinationally so the push carries it
  always_comb begin
    ferr_now = ferr_r | ~vote;
    brk_now  = (bidx == '0) ? (zero_acc & ~vote) : brk_r;
    entry    = {brk_now, ferr_now, perr_r, shreg};
  end

  assign full    = (count == (AW + 1)'(FIFO_DEPTH));
  assign do_pop  = rvalid & rready;
  assign do_push = push & (~full | do_pop);

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= entry;
  end

  // FIFO pointers, occupancy and drop pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push & full & ~do_pop;
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rvalid     = (count != '0);
  assign fifo_level = count;
  assign {rbreak, rferr, rperr, rdata} = rvalid ? mem[rptr] : '0;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - directed and randomized checks of uart_rx_cfg against a frame-level model
module tb_uart_rx_cfg;
  localparam int DIV    = 4;
  localparam int BITCLK = 4 * DIV;
  localparam int DEPTH  = 4;

  typedef struct {
    logic [31:0] data;
    logic        perr;
    logic        ferr;
    logic        brk;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx8 = 1'b1, rx7 = 1'b1;
  logic       rr8 = 1'b0, rr7 = 1'b0;
  logic       rv8, rv7, pe8, pe7, fe8, fe7, bk8, bk7, ov8, ov7;
  logic [7:0] rd8;
  logic [6:0] rd7;
  logic [2:0] lv8, lv7;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   n_ovf8 = 0, n_ovf7 = 0;
  int   exp_ovf8 = 0, exp_ovf7 = 0;
  ent_t q8[$];
  ent_t q7[$];

  uart_rx_cfg #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u8 (
    .clk(clk), .rst(rst), .rx(rx8), .rready(rr8), .rvalid(rv8), .rdata(rd8),
    .rperr(pe8), .rferr(fe8), .rbreak(bk8), .overflow(ov8), .fifo_level(lv8)
  );

  uart_rx_cfg #(.CLK_DIV(DIV), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u7 (
    .clk(clk), .rst(rst), .rx(rx7), .rready(rr7), .rvalid(rv7), .rdata(rd7),
    .rperr(pe7), .rferr(fe7), .rbreak(bk7), .overflow(ov7), .fifo_level(lv7)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (ov8) n_ovf8++;
    if (ov7) n_ovf7++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int nclk);
    repeat (nclk) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Build the line levels of one frame, record the expected FIFO entry, then drive it
  task automatic send(input int which, input logic [31:0] din, input bit pflip, input bit sbad,
                      input logic [15:0] gmask, input bit pop_at_push);
    int          nb, pm, ns, n, ones;
    logic        b[16];
    logic        pbit, lvl;
    logic [31:0] d;
    ent_t        e, hd;
    nb   = (which != 0) ? 7 : 8;
    pm   = (which != 0) ? 2 : 0;
    ns   = (which != 0) ? 2 : 1;
    d    = din & ((32'd1 << nb) - 1);
    ones = $countones(d);
    pbit = ((pm == 1) ? ~ones[0] : ones[0]) ^ pflip;
    b[0] = 1'b0;
    for (int i = 0; i < nb; i++) b[1 + i] = d[i];
    n = 1 + nb;
    if (pm != 0) begin
      b[n] = pbit;
      n++;
    end
    for (int k = 0; k < ns; k++) b[n + k] = !(sbad && k == 0);
    n = n + ns;
    e.data = d;
    e.perr = (pm != 0) && ((pm == 1) ? ((ones + pbit) % 2 == 0) : ((ones + pbit) % 2 == 1));
    e.ferr = sbad;
    e.brk  = (d == 0) && (pm == 0 || pbit == 1'b0) && sbad;
    hd = '{default: '0};
    if (which == 0) begin
      if (pop_at_push && q8.size() > 0) hd = q8.pop_front();
      if (q8.size() < DEPTH) q8.push_back(e);
      else exp_ovf8++;
    end else begin
      if (q7.size() < DEPTH) q7.push_back(e);
      else exp_ovf7++;
    end
    do begin
      @(posedge clk);
      #1;
    end while (cyc % DIV != 1);
    for (int t = 0; t < n * BITCLK; t++) begin
      lvl = b[t / BITCLK] ^ (gmask[t / BITCLK] && (t % BITCLK) >= 6 && (t % BITCLK) <= 9);
      if (which == 0) rx8 = lvl;
      else            rx7 = lvl;
      if (pop_at_push && t == n * BITCLK - 2) begin
        chk("pp_head", rd8, hd.data);
        rr8 = 1'b1;
      end
      if (pop_at_push && t == n * BITCLK - 1) rr8 = 1'b0;
      @(posedge clk);
      #1;
    end
    rx8 = 1'b1;
    rx7 = 1'b1;
  endtask

  // Compare the head against the model, then pop it with a one-cycle rready
  task automatic pop(input int which);
    ent_t        e;
    logic        v, pe, fe, bk;
    logic [31:0] d, lv;
    int          sz;
    v  = (which == 0) ? rv8 : rv7;
    d  = (which == 0) ? 32'(rd8) : 32'(rd7);
    pe = (which == 0) ? pe8 : pe7;
    fe = (which == 0) ? fe8 : fe7;
    bk = (which == 0) ? bk8 : bk7;
    lv = (which == 0) ? 32'(lv8) : 32'(lv7);
    sz = (which == 0) ? q8.size() : q7.size();
    chk("level", lv, 32'(sz));
    chk("rvalid", 32'(v), 32'(sz != 0));
    if (sz != 0) begin
      e = (which == 0) ? q8.pop_front() : q7.pop_front();
      chk("rdata", d, e.data);
      chk("rperr", 32'(pe), 32'(e.perr));
      chk("rferr", 32'(fe), 32'(e.ferr));
      chk("rbreak", 32'(bk), 32'(e.brk));
      if (which == 0) rr8 = 1'b1;
      else            rr7 = 1'b1;
      @(posedge clk);
      #1;
      rr8 = 1'b0;
      rr7 = 1'b0;
    end
  endtask

  task automatic drain(input int which);
    int sz;
    sz = (which == 0) ? q8.size() : q7.size();
    for (int i = 0; i < sz; i++) pop(which);
    pop(which);
  endtask

  initial begin
    int          w;
    logic [31:0] r;
    idle(3);
    chk("rst_rvalid", 32'(rv8), 0);
    chk("rst_outs8", {rd8, pe8, fe8, bk8, ov8, lv8}, 0);
    chk("rst_outs7", {rv7, rd7, pe7, fe7, bk7, ov7, lv7}, 0);
    rst = 1'b0;
    idle(2 * BITCLK);

    send(0, 32'hA5, 0, 0, 16'h0, 0);
    idle(BITCLK);
    pop(0);
    chk("basic_empty", {rv8, lv8}, 0);

    send(1, 32'h41, 0, 0, 16'h0, 0);
    idle(BITCLK);
    send(1, 32'h41, 1, 0, 16'h0, 0);
    idle(BITCLK);
    drain(1);

    send(0, 32'h3C, 0, 1, 16'h0, 0);
    idle(2 * BITCLK);
    q8.push_back('{data: 32'h0, perr: 1'b0, ferr: 1'b1, brk: 1'b1});
    do begin
      @(posedge clk);
      #1;
    end while (cyc % DIV != 1);
    rx8 = 1'b0;
    idle(12 * BITCLK);
    rx8 = 1'b1;
    idle(3 * BITCLK);
    chk("break_count", 32'(lv8), 2);
    drain(0);

    do begin
      @(posedge clk);
      #1;
    end while (cyc % DIV != 1);
    rx8 = 1'b0;
    idle(DIV);
    rx8 = 1'b1;
    idle(2 * BITCLK);
    chk("false_start", 32'(lv8), 0);
    send(0, 32'h55, 0, 0, 16'h0048, 0);
    idle(BITCLK);
    drain(0);

    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 3; i++) begin
        w = $urandom_range(0, 1);
        r = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
        send(w, r, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 16'h0, 0);
        idle(BITCLK);
      end
      drain(0);
      drain(1);
    end

    for (int i = 1; i <= 5; i++) begin
      send(0, 32'(i), 0, 0, 16'h0, 0);
      idle(BITCLK);
    end
    chk("ovf_pulses", 32'(n_ovf8), 32'(exp_ovf8));
    chk("ovf_level", 32'(lv8), 4);
    drain(0);

    for (int i = 1; i <= 4; i++) begin
      send(0, 32'h10 + 32'(i), 0, 0, 16'h0, 0);
      idle(BITCLK);
    end
    send(0, 32'h15, 0, 0, 16'h0, 1);
    idle(BITCLK);
    chk("pp_no_ovf", 32'(n_ovf8), 32'(exp_ovf8));
    chk("pp_level", 32'(lv8), 4);
    drain(0);

    send(0, 32'h21, 0, 0, 16'h0, 0);
    idle(BITCLK);
    send(0, 32'h22, 0, 0, 16'h0, 0);
    idle(BITCLK);
    chk("pre_rst_level", 32'(lv8), 2);
    do begin
      @(posedge clk);
      #1;
    end while (cyc % DIV != 1);
    for (int t = 0; t < 4 * BITCLK + 8; t++) begin
      rx8 = (t < BITCLK) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    rx8 = 1'b1;
    #1;
    chk("midrst_outs8", {rv8, rd8, pe8, fe8, bk8, ov8, lv8}, 0);
    chk("midrst_outs7", {rv7, lv7}, 0);
    idle(2);
    rst = 1'b0;
    q8.delete();
    q7.delete();
    idle(3 * BITCLK);
    chk("post_rst_empty", {rv8, lv8}, 0);
    send(0, 32'h81, 0, 0, 16'h0, 0);
    idle(BITCLK);
    chk("post_rst_level", 32'(lv8), 1);
    drain(0);
    chk("ovf7_pulses", 32'(n_ovf7), 32'(exp_ovf7));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver.
- Configurable data width, parity mode and stop-bit count, with 4x oversampling and majority voting.
- Per-frame parity, framing and break status.
- Received frames are buffered in an internal FIFO read through a valid/ready handshake.
- Sits between the board RX pin and any byte-consuming user logic, for example a command parser or a debug bridge.

Parameters:
CLK_DIV, 108, oversample tick period in clk cycles; baud = f_clk/(4*CLK_DIV); legal range 2..65535
DATA_BITS, 8, data bits per frame, 5..9, LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, receive FIFO entries, power of two, 2..256

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
rx  in  1  serial input, asynchronous, idle high
rready  in  1  consumer accepts head entry
rvalid  out  1  FIFO non-empty
rdata  out  DATA_BITS  head entry data
rperr  out  1  head entry parity error (always 0 when PARITY = 0)
rferr  out  1  head entry framing error (any stop bit sampled 0)
rbreak  out  1  head entry is a break (all data bits 0, parity bit 0 if present, first stop bit 0)
overflow  out  1  one-cycle pulse when a frame is dropped because the FIFO is full
fifo_level  out  $clog2(FIFO_DEPTH)+1  current entry count

Behaviour:
- Reset, asynchronous and active-high. Clears the synchroniser to 1, the tick counter to 0, the FSM to IDLE and the FIFO pointers.
- Output values while in reset: rvalid = 0, rdata = 0, rperr = rferr = rbreak = 0, overflow = 0, fifo_level = 0.
- Reset mid-frame discards the partial frame. Reset with the FIFO non-empty discards all stored entries.
- Synchroniser: 2 flops on rx. All sampling uses the synchronised value.
- Tick: counter 0..CLK_DIV-1, free-running. tick = 1 for one clk when the counter equals CLK_DIV-1.
- Each bit spans 4 ticks, phases 0..3. Samples are taken at phases 1, 2 and 3. Bit value = majority of the 3 samples, evaluated on the phase-3 tick.
- FSM states: IDLE, START, DATA, PARITY, STOP. The FSM advances only on ticks.
  - IDLE: on a tick where the sample is 0 and the previous tick sample was 1, enter START with phase 0. A line held low since reset does not start a frame.
  - START: at phase 3, majority 1 means false start, return to IDLE with no push. Majority 0 enters DATA with bit index 0.
  - DATA: shift the voted bit into the MSB of the shift register (LSB-first arrival). After DATA_BITS bits, go to PARITY if PARITY != 0, else to STOP.
  - PARITY: odd mode errors if the XOR of data and parity bit is 0. Even mode errors if that XOR is 1.
  - STOP: STOP_BITS bits. Any stop bit voted 0 sets ferr. After the last stop bit's phase 3, push {break, ferr, perr, data} and return to IDLE on the same tick.
- Framing error handling: IDLE needs a 1-sample followed by a 0-sample, so a line still low after a framing error is not re-triggered until it returns high.
- FIFO:
  - Push occurs on the cycle of the final stop-bit tick.
  - Show-ahead output: rvalid rises on the clk after the push; rdata and the flags are valid whenever rvalid = 1.
  - Pop when rvalid & rready.
  - Push while full with no pop: frame dropped, overflow = 1 for that cycle, FIFO contents unchanged.
  - Push while full with a pop in the same cycle: pop and push both succeed, fifo_level unchanged, no overflow.
  - Push while empty: data is not visible in the same cycle; there is no bypass.
  - Pointers wrap modulo FIFO_DEPTH. fifo_level is exact, 0..FIFO_DEPTH.
- Outputs are registered or driven straight from the FIFO RAM read at the head pointer. There are no combinational paths from rready to rvalid.

Test Plan:
- Basic frame. CLK_DIV=4, 8N1: drive 0xA5 at 16 clk/bit, then hold idle → rvalid=1 with rdata=0xA5, all flags 0. rready=1 → rvalid=0 on the next clk, fifo_level=0.
- Parity. DATA_BITS=7, PARITY=2, STOP_BITS=2: send 0x41 with correct even parity, then 0x41 with the parity bit inverted → entries 0x41 with rperr=0, then 0x41 with rperr=1, rferr=0 on both.
- Framing and break. 8N1: send 0x3C with the stop bit low, then a line held low for 12 bit times, then idle → 0x3C with rferr=1, then 0x00 with rbreak=1 and rferr=1. Exactly one entry for the break; no retrigger until the line returns high.
- Glitch rejection. 8N1: a 1-tick low pulse on an idle line (false start), then a 0x55 frame with 1-tick inverted glitches inside bits 2 and 5 → only 0x55 received, no flags.
- Overflow and full-plus-pop. FIFO_DEPTH=4, rready=0: send 5 frames (0x01..0x05) → fifo_level=4, a single overflow pulse on the 5th, the head reads 0x01..0x04 in order. Repeat with a pop issued on the cycle of the 5th push → no overflow, 0x05 retained.
- Reset mid-frame. Assert rst during DATA bit 3 for 2 clk, with 2 entries queued → all outputs 0 immediately. A following 0x81 frame is received correctly as the only entry.
